// File: rtl/madd_approx_eval.sv
// Two-stage multiply-add evaluator: exact a*b+c against a truncated approximation, with running error stats.
// Latency 2 cycles; valid/ready on both sides, holds 2 samples under backpressure, stats update on output handshake.
module madd_approx_eval #(
    parameter int N     = 6,
    parameter int TRUNC = 8,
    parameter int CNT_W = 32,
    parameter int SUM_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [N-1:0]     in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_exact,
    output logic [2*N-1:0]   out_approx,
    output logic [2*N-1:0]   out_err,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_samples,
    output logic [CNT_W-1:0] stat_errs,
    output logic [2*N-1:0]   stat_max_err,
    output logic [SUM_W-1:0] stat_sum_err
);
    localparam int W = 2 * N;
    // Ones in the TRUNC result columns that the approximations discard.
    localparam logic [W-1:0] LOW_MASK = {W{1'b1}} >> (W - TRUNC);

    logic             s1_vld_q;
    logic [N-1:0]     s1_a_q, s1_b_q, s1_c_q;
    logic [1:0]       s1_mode_q;
    logic             out_vld_q;
    logic [W-1:0]     exact_q, approx_q, err_q;
    logic [CNT_W-1:0] samples_q, samples_d, errs_q, errs_d;
    logic [W-1:0]     max_q, max_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    logic         out_adv, s1_adv, in_hs, out_hs;
    logic [W-1:0] exact_d, approx_d, err_d, col_d;
    logic [SUM_W:0] sum_ext;

    assign out_adv  = !out_vld_q || out_ready;
    assign s1_adv   = s1_vld_q && out_adv;
    assign in_ready = !s1_vld_q || s1_adv;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_vld_q && out_ready;

    always_comb begin
        exact_d = {{N{1'b0}}, s1_a_q} * {{N{1'b0}}, s1_b_q} + {{N{1'b0}}, s1_c_q};
        col_d   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (s1_a_q[i] && s1_b_q[j] && (i + j) >= TRUNC)
                    col_d = col_d + (W'(1) << (i + j));
            end
        end
        case (s1_mode_q)
            2'd0:    approx_d = exact_d;
            2'd1:    approx_d = exact_d & ~LOW_MASK;
            default: approx_d = col_d + ({{N{1'b0}}, s1_c_q} & ~LOW_MASK);
        endcase
        err_d = exact_d - approx_d;
    end

    always_comb begin
        samples_d = samples_q;
        errs_d    = errs_q;
        max_d     = max_q;
        sum_d     = sum_q;
        sum_ext   = {1'b0, sum_q} + {{(SUM_W + 1 - W){1'b0}}, err_q};
        if (stat_clr) begin
            // A handshake coinciding with the clear becomes the first sample of the new window.
            samples_d = out_hs ? CNT_W'(1) : '0;
            errs_d    = (out_hs && err_q != '0) ? CNT_W'(1) : '0;
            max_d     = out_hs ? err_q : '0;
            sum_d     = out_hs ? SUM_W'(err_q) : '0;
        end else if (out_hs) begin
            if (samples_q != {CNT_W{1'b1}})
                samples_d = samples_q + 1'b1;
            if (err_q != '0 && errs_q != {CNT_W{1'b1}})
                errs_d = errs_q + 1'b1;
            if (err_q > max_q)
                max_d = err_q;
            sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_c_q    <= '0;
            s1_mode_q <= '0;
            out_vld_q <= 1'b0;
            exact_q   <= '0;
            approx_q  <= '0;
            err_q     <= '0;
            samples_q <= '0;
            errs_q    <= '0;
            max_q     <= '0;
            sum_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_vld_q <= in_valid;
                if (in_valid) begin
                    s1_a_q    <= in_a;
                    s1_b_q    <= in_b;
                    s1_c_q    <= in_c;
                    s1_mode_q <= in_mode;
                end
            end
            if (out_adv) begin
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    exact_q  <= exact_d;
                    approx_q <= approx_d;
                    err_q    <= err_d;
                end
            end
            samples_q <= samples_d;
            errs_q    <= errs_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
        end
    end

    assign out_valid    = out_vld_q;
    assign out_exact    = exact_q;
    assign out_approx   = approx_q;
    assign out_err      = err_q;
    assign stat_samples = samples_q;
    assign stat_errs    = errs_q;
    assign stat_max_err = max_q;
    assign stat_sum_err = sum_q;
endmodule

// File: tb/tb_madd_approx_eval.sv
// Directed bench for madd_approx_eval at N=6, TRUNC=8: modes, latency, stats, backpressure, reset.
module tb_madd_approx_eval;
    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  in_a, in_b, in_c;
    logic [1:0]  in_mode;
    logic        out_valid, out_ready;
    logic [11:0] out_exact, out_approx, out_err;
    logic        stat_clr;
    logic [31:0] stat_samples, stat_errs;
    logic [11:0] stat_max_err;
    logic [39:0] stat_sum_err;

    int checks = 0;
    int failures = 0;

    madd_approx_eval #(.N(6), .TRUNC(8), .CNT_W(32), .SUM_W(40)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exact(out_exact), .out_approx(out_approx), .out_err(out_err),
        .stat_clr(stat_clr),
        .stat_samples(stat_samples), .stat_errs(stat_errs),
        .stat_max_err(stat_max_err), .stat_sum_err(stat_sum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row-wise reference: each partial-product row is shifted then stripped of the low 8 columns.
    function automatic logic [11:0] m_exact(input logic [5:0] a, b, c);
        return 12'(a) * 12'(b) + 12'(c);
    endfunction

    function automatic logic [11:0] m_approx(input logic [5:0] a, b, c, input logic [1:0] mode);
        logic [11:0] acc;
        acc = 12'd0;
        if (mode == 2'd0) return m_exact(a, b, c);
        if (mode == 2'd1) return m_exact(a, b, c) & 12'hF00;
        for (int j = 0; j < 6; j++)
            if (b[j]) acc = acc + ((12'(a) << j) & 12'hF00);
        return acc + (12'(c) & 12'hF00);
    endfunction

    // Presents one sample just after an edge; it is taken at the next edge and must appear
    // one edge later. Returns #1 after that, with the result still waiting for its handshake.
    task automatic send_one(input logic [5:0] a, b, c, input logic [1:0] mode,
                            input logic [11:0] ex, ap, er, input string name);
        in_a = a; in_b = b; in_c = c; in_mode = mode; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL %s early_valid got=%b want=0", name, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_exact !== ex || out_approx !== ap || out_err !== er) begin
            failures++;
            $display("FAIL %s got vld=%b exact=%0d approx=%0d err=%0d want vld=1 exact=%0d approx=%0d err=%0d",
                     name, out_valid, out_exact, out_approx, out_err, ex, ap, er);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_mode = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_exact !== 12'd0 || out_err !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b exact=%0d err=%0d want rdy=1 vld=0 exact=0 err=0",
                     in_ready, out_valid, out_exact, out_err);
        end
        checks++;
        if (stat_samples !== 0 || stat_errs !== 0 || stat_max_err !== 0 || stat_sum_err !== 0) begin
            failures++;
            $display("FAIL reset_stats got %0d %0d %0d %0d want all 0",
                     stat_samples, stat_errs, stat_max_err, stat_sum_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_modes;
        send_one(6'd63, 6'd63, 6'd63, 2'd0, 12'd4032, 12'd4032, 12'd0,    "mode0_max");
        send_one(6'd63, 6'd63, 6'd63, 2'd1, 12'd4032, 12'd3840, 12'd192,  "mode1_max");
        send_one(6'd63, 6'd63, 6'd63, 2'd2, 12'd4032, 12'd2816, 12'd1216, "mode2_max");
        checks++;
        if (stat_samples !== 32'd2) begin
            failures++; $display("FAIL stats_before_hs samples got=%0d want=2", stat_samples);
        end
        @(posedge clk); #1;
        checks++;
        if (stat_samples !== 32'd3 || stat_errs !== 32'd2 || stat_max_err !== 12'd1216 || stat_sum_err !== 40'd1408) begin
            failures++;
            $display("FAIL stats_three got samples=%0d errs=%0d max=%0d sum=%0d want 3 2 1216 1408",
                     stat_samples, stat_errs, stat_max_err, stat_sum_err);
        end
        send_one(6'd1, 6'd1, 6'd63, 2'd2, 12'd64, 12'd0, 12'd64, "mode2_all_dropped");
        send_one(6'd63, 6'd63, 6'd63, 2'd3, 12'd4032, 12'd2816, 12'd1216, "mode3_as_mode2");
        send_one(6'd0, 6'd0, 6'd0, 2'd2, 12'd0, 12'd0, 12'd0, "mode2_zero");
    endtask

    task automatic test_stat_clr;
        send_one(6'd63, 6'd63, 6'd63, 2'd1, 12'd4032, 12'd3840, 12'd192, "clr_sample");
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        checks++;
        if (stat_samples !== 32'd1 || stat_errs !== 32'd1 || stat_max_err !== 12'd192 || stat_sum_err !== 40'd192) begin
            failures++;
            $display("FAIL stat_clr_hs got samples=%0d errs=%0d max=%0d sum=%0d want 1 1 192 192",
                     stat_samples, stat_errs, stat_max_err, stat_sum_err);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] q_e[$], q_a[$], q_r[$];
        logic hs_in, hs_out, exp_rdy;
        int sent = 0, recv = 0, cyc = 0, inflight = 0;
        in_a = 6'($urandom_range(0, 63)); in_b = 6'($urandom_range(0, 63));
        in_c = 6'($urandom_range(0, 63)); in_mode = 2'($urandom_range(0, 3));
        in_valid = 1'b1; out_ready = 1'b0;
        while (recv < 10 && cyc < 300) begin
            @(negedge clk);
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            exp_rdy = !(inflight == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL bp_in_ready cyc=%0d got=%b want=%b inflight=%0d", cyc, in_ready, exp_rdy, inflight);
            end
            if (hs_out) begin
                checks++;
                if (q_e.size() == 0) begin
                    failures++; $display("FAIL bp_extra_output cyc=%0d exact=%0d want none", cyc, out_exact);
                end else begin
                    if (out_exact !== q_e[0] || out_approx !== q_a[0] || out_err !== q_r[0]) begin
                        failures++;
                        $display("FAIL bp_data idx=%0d got %0d/%0d/%0d want %0d/%0d/%0d", recv,
                                 out_exact, out_approx, out_err, q_e[0], q_a[0], q_r[0]);
                    end
                    void'(q_e.pop_front()); void'(q_a.pop_front()); void'(q_r.pop_front());
                end
                recv++;
            end
            if (hs_in) begin
                q_e.push_back(m_exact(in_a, in_b, in_c));
                q_a.push_back(m_approx(in_a, in_b, in_c, in_mode));
                q_r.push_back(m_exact(in_a, in_b, in_c) - m_approx(in_a, in_b, in_c, in_mode));
            end
            @(posedge clk); #1;
            inflight = inflight + int'(hs_in) - int'(hs_out);
            cyc++;
            if (hs_in) begin
                sent++;
                if (sent < 10) begin
                    in_a = 6'($urandom_range(0, 63)); in_b = 6'($urandom_range(0, 63));
                    in_c = 6'($urandom_range(0, 63)); in_mode = 2'($urandom_range(0, 3));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (cyc % 3 == 0);
        end
        checks++;
        if (recv != 10) begin
            failures++; $display("FAIL bp_timeout received=%0d want=10", recv);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        in_a = 6'd9; in_b = 6'd9; in_c = 6'd9; in_mode = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 6'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL rst_full got rdy=%b vld=%b want rdy=0 vld=1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stat_samples !== 0 || stat_sum_err !== 0 || stat_max_err !== 0) begin
            failures++;
            $display("FAIL rst_async got vld=%b rdy=%b samples=%0d sum=%0d max=%0d want 0 1 0 0 0",
                     out_valid, in_ready, stat_samples, stat_sum_err, stat_max_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL rst_ghost cyc=%0d got vld=%b want=0", k, out_valid);
            end
        end
        send_one(6'd5, 6'd7, 6'd3, 2'd0, 12'd38, 12'd38, 12'd0, "post_reset");
        @(posedge clk); #1;
        checks++;
        if (stat_samples !== 32'd1 || stat_errs !== 32'd0 || stat_sum_err !== 40'd0) begin
            failures++;
            $display("FAIL rst_stats got samples=%0d errs=%0d sum=%0d want 1 0 0",
                     stat_samples, stat_errs, stat_sum_err);
        end
    endtask

    initial begin
        test_reset;
        test_modes;
        test_stat_clr;
        test_back_to_back;
        test_reset_midflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
